// File: rtl/aes_pkg.sv
// =============================================================================
// aes_pkg : shared AES round-datapath widths, GF(2^8) helpers, FSM encoding
// Rev 1.0
// =============================================================================
`default_nettype none

package aes_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_COLS = STATE_W / COL_W;

  localparam logic [BYTE_W-1:0] GF_REDUCE = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] gmul_2(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_REDUCE : '0);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul_3(input logic [BYTE_W-1:0] a);
    return gmul_2(a) ^ a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mix_column_unit.sv
// =============================================================================
// mix_column_unit : combinational MixColumns transform of one 32-bit column
// Rev 1.0
// =============================================================================
`default_nettype none

module mix_column_unit
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;

  assign a0 = col_in[ 7: 0];
  assign a1 = col_in[15: 8];
  assign a2 = col_in[23:16];
  assign a3 = col_in[31:24];

  assign col_out[ 7: 0] = gmul_2(a0) ^ gmul_3(a1) ^ a2         ^ a3;
  assign col_out[15: 8] = a0         ^ gmul_2(a1) ^ gmul_3(a2) ^ a3;
  assign col_out[23:16] = a0         ^ a1         ^ gmul_2(a2) ^ gmul_3(a3);
  assign col_out[31:24] = gmul_3(a0) ^ a1         ^ a2         ^ gmul_2(a3);

endmodule

`default_nettype wire

// File: rtl/mix_columns_seq.sv
// =============================================================================
// mix_columns_seq : sequenced AES MixColumns with final-round bypass, valid/ready I/O
// Rev 1.0
// =============================================================================
`default_nettype none

module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mix_en,
  input  logic [STATE_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out
);

  // With four columns per cycle the step wraps to 0, keeping col constant.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % NUM_COLS);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_e             state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic               mode_q, mode_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] src_q, src_d;
  logic [STATE_W-1:0] result_q, result_d;

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] src_col [COLS_PER_CYCLE];
  logic [COL_W-1:0] mix_col [COLS_PER_CYCLE];

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign col_idx[i] = col_q + 2'(i);
    assign src_col[i] = src_q[{col_idx[i], 5'b0} +: COL_W];

    mix_column_unit u_mix (
      .col_in  (src_col[i]),
      .col_out (mix_col[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    mode_d      = mode_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    src_d       = src_q;
    result_d    = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          src_d      = data_in;
          mode_d     = mix_en;
          col_d      = 2'd0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          result_d[{col_idx[i], 5'b0} +: COL_W] = mode_q ? mix_col[i] : src_col[i];
        end
        col_d = col_q + COL_STEP;
        if (col_q == LAST_COL) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= 2'd0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      src_q       <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      src_q       <= src_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = result_q;

endmodule

`default_nettype wire

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequenced AES MixColumns engine for the round datapath.
- Accepts one 128-bit state and processes it through COLS_PER_CYCLE shared column units, one group of columns per cycle.
- Returns the mixed state through a valid/ready handshake.
- Sits between ShiftRows and AddRoundKey. Bypass mode serves the final round, which has no MixColumns.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per cycle. Legal values 1, 2, 4. Latency is 4/COLS_PER_CYCLE cycles.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  block can accept a state
- mix_en  input  1  1 = apply MixColumns, 0 = pass-through (final round); sampled with the state
- data_in  input  128  input state
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- data_out  output  128  result state

Behaviour:
- Byte layout:
  - Column c occupies data[32c+31:32c].
  - Row r of a column occupies that column's bits [8r+7:8r].
- Column unit, per column (a0..a3 = rows 0..3), in GF(2^8) with polynomial 0x11B:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid:
    - capture data_in into the source register and mix_en into the mode flag;
    - clear the column counter col;
    - go to BUSY.
  - BUSY: in_ready=0. Each cycle:
    - the result register receives the columns col..col+COLS_PER_CYCLE-1;
    - those columns are mixed outputs when the mode flag is 1, or unchanged source columns when it is 0;
    - col advances by COLS_PER_CYCLE;
    - on the cycle that writes column 3, go to DONE.
  - DONE: out_valid=1 and data_out = result register. Hold both stable until out_ready, then go to IDLE.
  - in_valid is ignored outside IDLE.
- Latency:
  - out_valid rises 4/COLS_PER_CYCLE clock edges after the acceptance edge.
  - Bypass mode has the same latency.
- Throughput:
  - One state per 4/COLS_PER_CYCLE+2 cycles with out_ready held high (accept, BUSY cycles, DONE, IDLE).
  - No overlap between states.
- Column counter:
  - 2 bits; wrap from 3 to 0 is never used.
  - For COLS_PER_CYCLE=4 the counter is constant 0 and BUSY lasts one cycle.
- Reset:
  - Reset asserted at any time, including mid-BUSY or while DONE is stalled, forces state=IDLE, col=0 and mode flag=0.
  - Source and result registers clear to 0, out_valid=0, data_out=0.
  - in_ready is 1 immediately after reset release.
  - A partially processed state is discarded.
- Backpressure: DONE with out_ready=0 holds indefinitely, with data_out unchanged and in_ready=0.
- No combinational path from in_valid/data_in to outputs, or from out_ready to in_ready.

Decomposition:
- Shared aes_pkg holds:
  - the GF reduction constant 8'h1B;
  - state, column and byte widths (128/32/8);
  - the FSM state encoding.
- Sub-module mix_column_unit:
  - combinational, 32-bit in/out;
  - built from the existing per-row multipliers and gmul_2;
  - instantiated COLS_PER_CYCLE times.

Test Plan:
- Reset then single state, mix_en=1, COLS_PER_CYCLE=1, out_ready=1:
  - data_in = 128'hd5d4d4d4_c6c6c6c6_5c220af2_455313db
  - -> data_out = 128'hd6d7d5d5_c6c6c6c6_9d58dc9f_bca14d8e
  - out_valid rises on the 4th edge after acceptance.
- Bypass, mix_en=0, same input -> data_out equals data_in with identical latency.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and data_out stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle.
- Reset asserted mid-BUSY (col=2) -> outputs 0 and in_ready=1 after release. A new state 128'h01010101_01010101_01010101_01010101 returns unchanged.
- Back-to-back, 8 random states per legal COLS_PER_CYCLE (1, 2, 4) against the reference model:
  - results match;
  - latency is 4/2/1 cycles respectively;
  - no state is dropped or duplicated.
- Simultaneous events: out_ready=1 in DONE while in_valid=1 -> the new state is not accepted until the following IDLE cycle.
